// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample sequencer and its tap counter.
package fir_pkg;

  localparam int FIR_WORD_LENGTH = 16;
  localparam int FIR_TAPS        = 32;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    CAPTURE,
    OUTPUT
  } fir_seq_state_t;

  // Smallest width that can hold values 0..n-1; never below 1 bit.
  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Sample-in, MAC and result-out signal bundle of the FIR sample sequencer.
// master: the sequencer itself; slave: upstream/MAC/downstream environment.
interface fir_sample_sequencer_if
  import fir_pkg::*;
#(
  parameter int WORD_LENGTH = FIR_WORD_LENGTH
);
  logic [WORD_LENGTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_LENGTH-1:0] mac_data;
  logic                   mac_enable;
  logic                   mac_sync_reset;
  logic [WORD_LENGTH-1:0] mac_result;
  logic [WORD_LENGTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  in_data, in_valid, mac_result, out_ready,
    output in_ready, mac_data, mac_enable, mac_sync_reset, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, mac_result, out_ready,
    input  in_ready, mac_data, mac_enable, mac_sync_reset, out_data, out_valid
  );
endinterface

// File: rtl/fir_seq_counter.sv
// Tap counter: synchronous clear, count enable, terminal-count flag at TAPS-1.
module fir_seq_counter
  import fir_pkg::*;
#(
  parameter int TAPS  = FIR_TAPS,
  parameter int WIDTH = CeilLog2(FIR_TAPS)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);
  logic [WIDTH-1:0] cnt;

  assign tc = (cnt == WIDTH'(TAPS - 1));

  // Clear has priority so every sweep starts at tap 0; the last tap wraps to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/fir_sample_sequencer.sv
// FIR sample sequencer: holds one sample on the MAC input for exactly TAPS
// enabled cycles, strobes the MAC sync reset, captures the result and hands
// it downstream. Optional build macro FIR_SEQ_SAMPLE_COUNT_EN adds a 16-bit
// count of completed output handshakes on port sample_count.
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int WORD_LENGTH       = FIR_WORD_LENGTH,
  parameter int TAPS              = FIR_TAPS,
  parameter int NBITS_FOR_COUNTER = CeilLog2(TAPS)
) (
  input  logic                          clk,
  input  logic                          reset,
  fir_sample_sequencer_if.master        bus
`ifdef FIR_SEQ_SAMPLE_COUNT_EN
  ,
  output logic [15:0]                   sample_count
`endif
);
  fir_seq_state_t         state, state_nxt;
  logic [WORD_LENGTH-1:0] sample_reg;
  logic [WORD_LENGTH-1:0] out_reg;
  logic                   accept;
  logic                   tap_last;

  fir_seq_counter #(
    .TAPS  (TAPS),
    .WIDTH (NBITS_FOR_COUNTER)
  ) u_tap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state == RUN),
    .tc    (tap_last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; one sweep of TAPS enables per accepted sample.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE:    if (bus.in_valid) begin
                 accept    = 1'b1;
                 state_nxt = RUN;
               end
      RUN:     if (tap_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUTPUT;
      OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample is latched only on acceptance and held for the whole sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sample_reg <= '0;
    else if (accept) sample_reg <= bus.in_data;
  end

  // The MAC registered its sum during FLUSH, so it is valid in CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 out_reg <= '0;
    else if (state == CAPTURE) out_reg <= bus.mac_result;
  end

`ifdef FIR_SEQ_SAMPLE_COUNT_EN
  // Completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    sample_count <= '0;
    else if (state == OUTPUT && bus.out_ready)    sample_count <= sample_count + 16'd1;
  end
`endif

  // All outputs are state decodes or registers: no input-to-output paths.
  assign bus.in_ready       = (state == IDLE);
  assign bus.mac_enable     = (state == RUN);
  assign bus.mac_sync_reset = (state == FLUSH);
  assign bus.out_valid      = (state == OUTPUT);
  assign bus.mac_data       = sample_reg;
  assign bus.out_data       = out_reg;
endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Control stage directly upstream of the FIR MAC accumulator. Accepts one input sample per valid/ready handshake, holds it stable on the MAC data input while driving the MAC enable for exactly TAPS cycles, then pulses the MAC sync-reset so the accumulator registers its result and restarts. It captures that result and presents it downstream with a valid/ready handshake, so the MAC never sees a partial tap sweep.

## Interface
- WORD_LENGTH, 16: sample and result width.
- TAPS, 32: coefficient count; must equal the MAC's coefficient counter maximum value.
- NBITS_FOR_COUNTER, CeilLog2(TAPS): tap counter width.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WORD_LENGTH  input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer can accept a sample.
- mac_data  output  WORD_LENGTH  held sample to MAC DataInput.
- mac_enable  output  1  MAC enable.
- mac_sync_reset  output  1  MAC sync_reset / result strobe.
- mac_result  input  WORD_LENGTH  MAC DataOutput.
- out_data  output  WORD_LENGTH  filtered sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_data into sample_reg, clear tap_cnt, go to RUN.
  - RUN: mac_enable=1 and mac_data=sample_reg. tap_cnt increments each cycle. When tap_cnt==TAPS-1, go to FLUSH.
  - FLUSH: mac_enable=0 and mac_sync_reset=1 for exactly one cycle. Go to CAPTURE.
  - CAPTURE: load out_reg from mac_result, which the MAC registered during FLUSH. Go to OUTPUT.
  - OUTPUT: out_valid=1. On out_ready, go to IDLE.
- in_ready is high only in IDLE. Samples offered in any other state are not accepted, and the upstream must hold them.
- mac_data is driven from sample_reg in every state. It is stable from the first RUN cycle through FLUSH.
- out_data holds its last value outside OUTPUT and changes only on the CAPTURE edge.
- No arithmetic on data. tap_cnt wraps to 0 on the RUN→FLUSH transition.
- Reset at any point returns the FSM to IDLE and zeroes sample_reg, tap_cnt and out_reg. No partial result is emitted. mac_enable and mac_sync_reset drop in the same cycle.
- in_valid asserted in the same cycle reset deasserts is ignored. Acceptance starts on the first edge with reset low.

## Timing
- Reset values:
  - in_ready=1, since it is decoded from IDLE.
  - mac_enable=0, mac_sync_reset=0, out_valid=0.
  - mac_data=0, out_data=0.
- Accept at edge A: mac_enable is high for cycles A+1 through A+TAPS.
- mac_sync_reset is high for cycle A+TAPS+1.
- CAPTURE is cycle A+TAPS+2. out_valid rises after edge A+TAPS+2, so it is high from cycle A+TAPS+3.
- Output handshake completes on the first edge with out_valid & out_ready. in_ready is high the next cycle.
- Minimum sample period is TAPS+4 cycles, achieved with out_ready held high.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Configuration
- FIR_SEQ_SAMPLE_COUNT_EN defined:
  - Adds output port sample_count [15:0], reset 0.
  - It increments by 1 on each completed output handshake and wraps 0xFFFF→0x0000.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package fir_pkg holds:
  - the state enum fir_seq_state_t (IDLE, RUN, FLUSH, CAPTURE, OUTPUT);
  - the default constants FIR_WORD_LENGTH=16 and FIR_TAPS=32;
  - the CeilLog2 function.
- One sub-module: fir_seq_counter, the tap counter with load-clear, enable and terminal-count flag at TAPS-1.
- FSM, sample register and output register live in the top.

## Test plan
- Reset then idle: assert reset for 3 cycles with in_valid=1 → in_ready=1, mac_enable=0, out_valid=0, out_data=0; no acceptance before reset drops.
- Single sample: in_data=0x1234 accepted at edge A, out_ready=1 → mac_enable high exactly 32 cycles with mac_data=0x1234; mac_sync_reset high only at A+33; mac_result stub value 0x0ABC → out_data=0x0ABC, out_valid high from A+35 for 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles in OUTPUT → out_valid and out_data stable, in_ready=0, new in_valid ignored; release → accepted the cycle after handshake.
- Back-to-back: in_valid held high with samples 0x0001, 0x0002, 0x0003 and out_ready=1 → accepts spaced exactly 36 cycles apart; outputs in order.
- Reset mid-RUN: assert reset at tap 15 → mac_enable=0 immediately, no out_valid; the next sample 0x0055 runs a full 32-cycle sweep.
- With FIR_SEQ_SAMPLE_COUNT_EN: preload via 3 outputs → sample_count=3; force the counter to 0xFFFF and complete one output → 0x0000.
